fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined CPU, directly upstream of the fetch/decode pipeline register. Owns the program counter and issues requests to a variable-latency instruction memory. Applies decode-stage branch/jump redirects. Delivers `instr_f` / `pc_plus_4_f` plus a bubble request (`sig_clr`) to the F/D register, and honours the same `haz_enable` stall that freezes the F/D register.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the bubble performance counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `haz_enable` in 1: 1 = the pipeline advances this cycle; 0 = F/D is stalled.
- `branch_taken_d` in 1: decode resolved a taken branch.
- `branch_target_d` in 32: branch target address.
- `jump_d` in 1: decode holds a jump.
- `jump_target_d` in 32: jump target address.
- `imem_req` out 1: fetch request is valid.
- `imem_addr` out 32: fetch address, always equal to `pc_f`.
- `imem_ready` in 1: `imem_rdata` is valid for the current `imem_addr` this cycle.
- `imem_rdata` in 32: instruction word.
- `instr_f` out 32: instruction presented to F/D.
- `pc_f` out 32: current PC.
- `pc_plus_4_f` out 32: `pc_f + 4`, computed mod 2^32.
- `sig_clr` out 1: requests that F/D load a bubble.
- `bubble_cnt` out CNT_W: saturating count of bubbles inserted.

## Operation
- **Registers:**
  - `pc_f`
  - `state` ∈ {FETCH, HELD}
  - `held_instr` [31:0]
  - `bubble_cnt`
- **Redirect** is defined as `redir = haz_enable & (branch_taken_d | jump_d)`.
  - Target is `branch_target_d` if `branch_taken_d`, else `jump_target_d`; branch has priority.
  - Redirect inputs are ignored while `haz_enable` = 0.
- **FETCH:**
  - `imem_req` = 1, `imem_addr` = `pc_f`.
  - If `imem_ready`:
    - `instr_f` = `imem_rdata`, `sig_clr` = 0.
    - If `haz_enable`: next `pc_f` = `pc_f` + 4 and stay in FETCH.
    - Else: capture `imem_rdata` into `held_instr` → HELD; `pc_f` unchanged.
  - If not `imem_ready`: `instr_f` = 0, `sig_clr` = 1; `pc_f` unchanged.
- **HELD:**
  - `imem_req` = 0, `instr_f` = `held_instr`, `sig_clr` = 0.
  - If `haz_enable`: `pc_f` += 4 → FETCH.
  - Else: hold.
- **Redirect (any state)** overrides the above:
  - `sig_clr` = 1 and `instr_f` = 0; the wrong-path fetch is squashed.
  - Next `pc_f` = target; state → FETCH.
  - Any `imem_ready` in the same cycle is ignored.
  - An outstanding request is abandoned. The memory treats an address change as a new request.
- **Bubble counter:** `bubble_cnt` increments when `sig_clr & haz_enable` (a bubble actually loaded into F/D) and saturates at all-ones.
- **PC arithmetic** is unsigned 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0. Targets are taken unmodified; the low 2 bits are not forced.

## Timing
- **Reset (async, immediate):**
  - `pc_f` = `RESET_PC`, state = FETCH, `held_instr` = 0, `bubble_cnt` = 0.
  - While `rst` = 1: `imem_req` = 0, `sig_clr` = 1, `instr_f` = 0.
  - First request is issued in the first cycle after `rst` deasserts.
  - Reset mid-request or in HELD discards everything.
- **Outputs:** `instr_f`, `sig_clr`, `imem_req` and `imem_addr` are combinational from state/inputs. `pc_f`, `pc_plus_4_f` and `bubble_cnt` are registered.
- **Throughput:** with `imem_ready` tied high and no stall/redirect, one instruction per cycle and `pc_f` advances by 4 every edge.
- **Memory latency:** N wait cycles produce exactly N bubbles when `haz_enable` = 1.
- **Redirect penalty:** one bubble; the target is requested in the cycle after redirect.
- **Redirect + `imem_ready` + `haz_enable` = 0 in the same cycle:** not a redirect (ignored); behaves as a stall capture → HELD.
- **Stall with no data:** the request stays asserted and `pc_f` is unchanged. Bubbles are not counted, because `haz_enable` = 0.

## Test plan
- **Reset/stream:** reset with `RESET_PC` = 32'h100; release; `imem_ready` = 1, `haz_enable` = 1 for 4 cycles → `imem_addr` = 100, 104, 108, 10C; `sig_clr` = 0 throughout; `bubble_cnt` = 0.
- **Latency:** `imem_ready` low 3 cycles at PC 0x8 → `sig_clr` = 1 for 3 cycles, `bubble_cnt` = 3, `pc_f` held at 0x8; then the instruction is delivered and `pc_f` = 0xC.
- **Stall capture:** `imem_ready` = 1 with `imem_rdata` = 32'hDEADBEEF while `haz_enable` = 0 for 2 cycles → HELD, `imem_req` = 0, `instr_f` = DEADBEEF held; `haz_enable` = 1 → `pc_f` += 4, `imem_req` = 1.
- **Redirect:**
  - `branch_taken_d` = 1, target 0x200, `haz_enable` = 1 → `sig_clr` = 1 that cycle, next `imem_addr` = 0x200.
  - `branch_taken_d` and `jump_d` both set (jump target 0x300) → next PC = 0x200.
  - Same redirect with `haz_enable` = 0 → ignored.
- **Wrap/saturation:**
  - `pc_f` = 32'hFFFF_FFFC with a fetch delivered → next `pc_f` = 0.
  - With `CNT_W` = 2, 5 bubbles → `bubble_cnt` = 3.
- **Async reset mid-HELD:** assert `rst` between edges → `pc_f` = `RESET_PC` and `sig_clr` = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined CPU.
// Owns the program counter, issues requests to a variable-latency instruction
// memory, applies decode-stage branch/jump redirects and delivers the fetched
// word (or a bubble request) to the fetch/decode pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             haz_enable,
   input  logic             branch_taken_d,
   input  logic [31:0]      branch_target_d,
   input  logic             jump_d,
   input  logic [31:0]      jump_target_d,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr_f,
   output logic [31:0]      pc_f,
   output logic [31:0]      pc_plus_4_f,
   output logic             sig_clr,
   output logic [CNT_W-1:0] bubble_cnt
);

   // FETCH: a request is outstanding for pc_f.
   // HELD:  the word for pc_f arrived during a stall and is parked in held_instr.
   typedef enum logic {
      FETCH = 1'b0,
      HELD  = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] held_instr;
   logic        redir;
   logic [31:0] redir_target;

   // Redirects only count while the pipeline advances; branch beats jump.
   always_comb begin
      redir        = haz_enable & (branch_taken_d | jump_d);
      redir_target = branch_taken_d ? branch_target_d : jump_target_d;
   end

   // The address bus always mirrors the current PC; a new address is a new request.
   assign imem_addr = pc_f;

   // Combinational view of the stage towards memory and the F/D register.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      imem_req = 1'b0;
      instr_f  = 32'h0000_0000;
      sig_clr  = 1'b1;
      if (!rst) begin
         if (redir) begin
            // Wrong-path word is squashed; any imem_ready this cycle is ignored.
            imem_req = (state == FETCH);
            instr_f  = 32'h0000_0000;
            sig_clr  = 1'b1;
         end else begin
            unique case (state)
               FETCH: begin
                  imem_req = 1'b1;
                  if (imem_ready) begin
                     instr_f = imem_rdata;
                     sig_clr = 1'b0;
                  end else begin
                     instr_f = 32'h0000_0000;
                     sig_clr = 1'b1;
                  end
               end
               HELD: begin
                  imem_req = 1'b0;
                  instr_f  = held_instr;
                  sig_clr  = 1'b0;
               end
               default: begin
                  imem_req = 1'b0;
                  instr_f  = 32'h0000_0000;
                  sig_clr  = 1'b1;
               end
            endcase
         end
      end
   end

   // PC / state machine: advance, hold, capture during stall, or redirect.
   // pc_plus_4_f is kept as its own register so advancing is just pc_f <= pc_plus_4_f.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: held_instr is a single pipeline word, not a memory, so it is reset like any flop.
         state       <= FETCH;
         pc_f        <= RESET_PC;
         pc_plus_4_f <= RESET_PC + 32'd4;
         held_instr  <= 32'h0000_0000;
      end else if (redir) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state       <= FETCH;
         pc_f        <= redir_target;
         pc_plus_4_f <= redir_target + 32'd4;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (haz_enable) begin
                     pc_f        <= pc_plus_4_f;
                     pc_plus_4_f <= pc_plus_4_f + 32'd4;
                  end else begin
                     held_instr  <= imem_rdata;
                     state       <= HELD;
                  end
               end
            end
            HELD: begin
               if (haz_enable) begin
                  pc_f        <= pc_plus_4_f;
                  pc_plus_4_f <= pc_plus_4_f + 32'd4;
                  state       <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   // Saturating count of bubbles actually loaded into F/D.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (sig_clr && haz_enable && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Main instance uses RESET_PC = 0x100; a second instance with CNT_W = 2 sits
// under constant memory wait to show counter saturation.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        haz_enable;
   logic        branch_taken_d;
   logic [31:0] branch_target_d;
   logic        jump_d;
   logic [31:0] jump_target_d;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] pc_plus_4_f;
   logic        sig_clr;
   logic [15:0] bubble_cnt;

   // Saturation instance: always stalled on memory, pipeline always advancing.
   logic        s_haz_enable;
   logic        s_branch_taken_d;
   logic [31:0] s_branch_target_d;
   logic        s_jump_d;
   logic [31:0] s_jump_target_d;
   logic        s_imem_ready;
   logic [31:0] s_imem_rdata;
   logic        s_imem_req;
   logic [31:0] s_imem_addr;
   logic [31:0] s_instr_f;
   logic [31:0] s_pc_f;
   logic [31:0] s_pc_plus_4_f;
   logic        s_sig_clr;
   logic [1:0]  s_bubble_cnt;

   int n_checks;
   int n_errors;

   fetch_stage #(.RESET_PC(32'h0000_0100), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .haz_enable      (haz_enable),
      .branch_taken_d  (branch_taken_d),
      .branch_target_d (branch_target_d),
      .jump_d          (jump_d),
      .jump_target_d   (jump_target_d),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .instr_f         (instr_f),
      .pc_f            (pc_f),
      .pc_plus_4_f     (pc_plus_4_f),
      .sig_clr         (sig_clr),
      .bubble_cnt      (bubble_cnt)
   );

   fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_sat (
      .clk             (clk),
      .rst             (rst),
      .haz_enable      (s_haz_enable),
      .branch_taken_d  (s_branch_taken_d),
      .branch_target_d (s_branch_target_d),
      .jump_d          (s_jump_d),
      .jump_target_d   (s_jump_target_d),
      .imem_req        (s_imem_req),
      .imem_addr       (s_imem_addr),
      .imem_ready      (s_imem_ready),
      .imem_rdata      (s_imem_rdata),
      .instr_f         (s_instr_f),
      .pc_f            (s_pc_f),
      .pc_plus_4_f     (s_pc_plus_4_f),
      .sig_clr         (s_sig_clr),
      .bubble_cnt      (s_bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic haz, input logic rdy, input logic [31:0] rdata);
      haz_enable = haz;
      imem_ready = rdy;
      imem_rdata = rdata;
   endtask

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      rst               = 1'b1;
      haz_enable        = 1'b0;
      branch_taken_d    = 1'b0;
      branch_target_d   = 32'h0;
      jump_d            = 1'b0;
      jump_target_d     = 32'h0;
      imem_ready        = 1'b0;
      imem_rdata        = 32'h0;
      s_haz_enable      = 1'b1;
      s_branch_taken_d  = 1'b0;
      s_branch_target_d = 32'h0;
      s_jump_d          = 1'b0;
      s_jump_target_d   = 32'h0;
      s_imem_ready      = 1'b0;
      s_imem_rdata      = 32'h0;

      // Reset state.
      step();
      step();
      check("rst_pc",       pc_f,               32'h100);
      check("rst_pc4",      pc_plus_4_f,        32'h104);
      check("rst_req",      {31'b0, imem_req},  32'h0);
      check("rst_clr",      {31'b0, sig_clr},   32'h1);
      check("rst_instr",    instr_f,            32'h0);
      check("rst_bcnt",     {16'b0, bubble_cnt}, 32'h0);
      check("rst_sat_bcnt", {30'b0, s_bubble_cnt}, 32'h0);

      // Stream: memory always ready, no stall.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_inputs(1'b1, 1'b1, 32'hA000_0000 + 32'(i));
         #1;
         check("stream_addr",  imem_addr,         32'h100 + 32'(4 * i));
         check("stream_req",   {31'b0, imem_req}, 32'h1);
         check("stream_clr",   {31'b0, sig_clr},  32'h0);
         check("stream_instr", instr_f,           32'hA000_0000 + 32'(i));
         step();
         if (i == 1) check("sat_bcnt_2", {30'b0, s_bubble_cnt}, 32'h2);
      end
      check("stream_pc",   pc_f,                 32'h110);
      check("stream_bcnt", {16'b0, bubble_cnt},  32'h0);
      check("sat_bcnt_4",  {30'b0, s_bubble_cnt}, 32'h3);

      // Jump to 0x8 (one redirect bubble), then 3 memory wait cycles.
      set_inputs(1'b1, 1'b1, 32'h5555_5555);
      jump_d        = 1'b1;
      jump_target_d = 32'h8;
      #1;
      check("jmp_clr",   {31'b0, sig_clr}, 32'h1);
      check("jmp_instr", instr_f,          32'h0);
      step();
      jump_d = 1'b0;
      check("sat_bcnt_5", {30'b0, s_bubble_cnt}, 32'h3);
      check("jmp_addr",   imem_addr,            32'h8);
      check("jmp_bcnt",   {16'b0, bubble_cnt},  32'h1);
      for (int i = 0; i < 3; i++) begin
         set_inputs(1'b1, 1'b0, 32'h0);
         #1;
         check("lat_clr",   {31'b0, sig_clr},  32'h1);
         check("lat_req",   {31'b0, imem_req}, 32'h1);
         check("lat_instr", instr_f,           32'h0);
         step();
         check("lat_pc", pc_f, 32'h8);
      end
      check("lat_bcnt", {16'b0, bubble_cnt}, 32'h4);
      set_inputs(1'b1, 1'b1, 32'h1111_1111);
      #1;
      check("lat_deliver", instr_f,          32'h1111_1111);
      check("lat_dclr",    {31'b0, sig_clr}, 32'h0);
      step();
      check("lat_pc_next", pc_f,                32'hC);
      check("lat_bcnt2",   {16'b0, bubble_cnt}, 32'h4);

      // Stall with no data: request held, no bubble counted.
      set_inputs(1'b0, 1'b0, 32'h0);
      #1;
      check("nodata_req", {31'b0, imem_req}, 32'h1);
      check("nodata_clr", {31'b0, sig_clr},  32'h1);
      step();
      check("nodata_pc",   pc_f,                32'hC);
      check("nodata_bcnt", {16'b0, bubble_cnt}, 32'h4);

      // Stall capture into HELD.
      set_inputs(1'b0, 1'b1, 32'hDEAD_BEEF);
      #1;
      check("cap_instr", instr_f,          32'hDEAD_BEEF);
      check("cap_clr",   {31'b0, sig_clr}, 32'h0);
      step();
      for (int i = 0; i < 2; i++) begin
         set_inputs(1'b0, 1'b0, 32'h0);
         #1;
         check("held_req",   {31'b0, imem_req}, 32'h0);
         check("held_instr", instr_f,           32'hDEAD_BEEF);
         check("held_clr",   {31'b0, sig_clr},  32'h0);
         step();
         check("held_pc", pc_f, 32'hC);
      end
      set_inputs(1'b1, 1'b1, 32'h2222_2222);
      #1;
      check("held_rel_instr", instr_f, 32'hDEAD_BEEF);
      step();
      check("held_rel_pc",    pc_f,                32'h10);
      check("held_rel_req",   {31'b0, imem_req},   32'h1);
      check("held_rel_next",  instr_f,             32'h2222_2222);
      check("held_rel_bcnt",  {16'b0, bubble_cnt}, 32'h4);

      // Redirect while stalled is ignored and behaves as a stall capture.
      set_inputs(1'b0, 1'b1, 32'h3333_3333);
      branch_taken_d  = 1'b1;
      branch_target_d = 32'h200;
      jump_d          = 1'b1;
      jump_target_d   = 32'h300;
      #1;
      check("ign_clr",   {31'b0, sig_clr}, 32'h0);
      check("ign_instr", instr_f,          32'h3333_3333);
      step();
      check("ign_pc",  pc_f,              32'h10);
      check("ign_req", {31'b0, imem_req}, 32'h0);

      // Same branch+jump with the pipeline advancing: branch wins, from HELD.
      set_inputs(1'b1, 1'b0, 32'h0);
      #1;
      check("prio_clr",   {31'b0, sig_clr}, 32'h1);
      check("prio_instr", instr_f,          32'h0);
      step();
      branch_taken_d = 1'b0;
      jump_d         = 1'b0;
      check("prio_addr", imem_addr,           32'h200);
      check("prio_bcnt", {16'b0, bubble_cnt}, 32'h5);

      // Branch alone with a ready word in the same cycle: word squashed.
      set_inputs(1'b1, 1'b1, 32'h4444_4444);
      branch_taken_d  = 1'b1;
      branch_target_d = 32'h400;
      #1;
      check("br_clr",   {31'b0, sig_clr}, 32'h1);
      check("br_instr", instr_f,          32'h0);
      step();
      branch_taken_d = 1'b0;
      check("br_addr", imem_addr,           32'h400);
      check("br_pc4",  pc_plus_4_f,         32'h404);
      check("br_bcnt", {16'b0, bubble_cnt}, 32'h6);

      // PC wrap at the top of the address space.
      jump_d        = 1'b1;
      jump_target_d = 32'hFFFF_FFFC;
      #1;
      step();
      jump_d = 1'b0;
      set_inputs(1'b1, 1'b1, 32'h6666_6666);
      #1;
      check("wrap_pc",  pc_f,        32'hFFFF_FFFC);
      check("wrap_pc4", pc_plus_4_f, 32'h0);
      step();
      check("wrap_next", pc_f, 32'h0);

      // Async reset while HELD, between clock edges.
      set_inputs(1'b0, 1'b1, 32'h7777_7777);
      #1;
      step();
      check("pre_rst_req", {31'b0, imem_req}, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("async_pc",    pc_f,                32'h100);
      check("async_clr",   {31'b0, sig_clr},    32'h1);
      check("async_req",   {31'b0, imem_req},   32'h0);
      check("async_instr", instr_f,             32'h0);
      check("async_bcnt",  {16'b0, bubble_cnt}, 32'h0);
      #1;
      rst = 1'b0;
      set_inputs(1'b1, 1'b1, 32'h8888_8888);
      #1;
      check("post_rst_req", {31'b0, imem_req}, 32'h1);
      check("post_rst_instr", instr_f,         32'h8888_8888);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
